// File: rtl/disp_load_seq.sv
`default_nettype none
// ============================================================================
//  Module      : disp_load_seq
//  Description : Load sequencer for a 4-digit multiplexed 7-segment display.
//                Accepts a value via start/busy/done, optionally converts it
//                to 4 BCD digits (sequential shift-add-3), then issues two
//                single-cycle byte loads: low byte on load0, high on load1.
//  Ports       : clk, rst      - clock (also display load clock), async reset
//                start         - request, sampled only in IDLE
//                hex_mode      - 1 = hex nibbles, 0 = decimal BCD
//                value         - number to display
//                busy          - high in CONV, LOAD0, LOAD1
//                done          - one-cycle completion pulse
//                ovf           - last decimal request saturated
//                data          - byte presented to the display
//                load0, load1  - one-cycle load strobes (low / high byte)
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_load_seq #(
    parameter int VAL_W   = 16,
    parameter int SAT_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hex_mode,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [7:0]       data,
    output logic             load0,
    output logic             load1
);

    localparam int                 CNT_W   = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0]   LAST_IT = CNT_W'(VAL_W - 1);
    localparam logic [VAL_W-1:0]   SAT     = VAL_W'(SAT_VAL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_LOAD0 = 3'd2,
        S_LOAD1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [VAL_W-1:0]   r_op;
    logic [15:0]        r_bcd;
    logic [15:0]        r_digits;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [7:0]         r_data;

    logic               w_accept;
    logic               w_last;
    logic               w_sat;
    logic [15:0]        w_val_ext;
    logic [15:0]        w_adj;
    logic [15:0]        w_shift;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == LAST_IT);
    assign w_sat    = (value > SAT);

    // Zero-extend the input to four hex digits for any legal VAL_W.
    always_comb begin
        w_val_ext             = '0;
        w_val_ext[VAL_W-1:0]  = value;
    end

    // Shift-add-3 step: correct every nibble >= 5, then shift in the
    // operand MSB. The thousands nibble never carries out since the
    // operand is saturated to at most 9999.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj[14:0], r_op[VAL_W-1]};
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = hex_mode ? S_LOAD0 : S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_next = S_LOAD0;
                end
            end
            S_LOAD0: w_next = S_LOAD1;
            S_LOAD1: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_bcd    <= '0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_accept) begin
                if (hex_mode) begin
                    r_digits <= w_val_ext;
                    r_ovf    <= 1'b0;
                end else begin
                    r_op     <= w_sat ? SAT : value;
                    r_ovf    <= w_sat;
                    r_bcd    <= '0;
                    r_cnt    <= '0;
                end
            end
            if (r_state == S_CONV) begin
                r_bcd <= w_shift;
                r_op  <= r_op << 1;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_digits <= w_shift;
                end
            end
            // Remember the last byte driven so data holds between loads.
            if (r_state == S_LOAD0) begin
                r_data <= r_digits[7:0];
            end
            if (r_state == S_LOAD1) begin
                r_data <= r_digits[15:8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register and datapath registers
    // only, so reset clears them immediately and no input reaches them.
    // ------------------------------------------------------------------
    assign busy  = (r_state == S_CONV) || (r_state == S_LOAD0) || (r_state == S_LOAD1);
    assign done  = (r_state == S_DONE);
    assign load0 = (r_state == S_LOAD0);
    assign load1 = (r_state == S_LOAD1);
    assign ovf   = r_ovf;

    always_comb begin
        data = r_data;
        if (r_state == S_LOAD0) begin
            data = r_digits[7:0];
        end else if (r_state == S_LOAD1) begin
            data = r_digits[15:8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_load_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_load_seq
//  Description : Directed testbench for disp_load_seq. Expected load bytes
//                and done-time ovf values are queued when a request is
//                issued and compared when the DUT strobes them out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_load_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hex_mode;
    logic [15:0] value;
    logic        busy, done, ovf, load0, load1;
    logic [7:0]  data;

    typedef struct packed {
        logic       hi;
        logic [7:0] byte_v;
    } ld_t;

    ld_t  exp_q[$];
    logic ovf_q[$];

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    disp_load_seq #(.VAL_W(16), .SAT_VAL(9999)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hex_mode (hex_mode),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .data     (data),
        .load0    (load0),
        .load1    (load1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference digits computed arithmetically.
    function automatic logic [15:0] model_digits(input bit hx, input logic [15:0] v);
        int s;
        if (hx) return v;
        s = (v > 16'd9999) ? 9999 : int'(v);
        return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (load0 === 1'b1 && load1 === 1'b1) begin
                chk("load_overlap", 32'd1, 32'd0);
            end
            if (load0 === 1'b1 || load1 === 1'b1) begin
                ld_t e;
                strobes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {load1, load0}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {load1, load0}, e.hi ? 32'd2 : 32'd1);
                    chk(e.hi ? "data_hi" : "data_lo", data, e.byte_v);
                end
            end
            if (done === 1'b1) begin
                if (ovf_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("ovf_at_done", ovf, ovf_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input bit hx, input logic [15:0] v);
        logic [15:0] d;
        d = model_digits(hx, v);
        exp_q.push_back('{hi: 1'b0, byte_v: d[7:0]});
        exp_q.push_back('{hi: 1'b1, byte_v: d[15:8]});
        ovf_q.push_back(!hx && (v > 16'd9999));
    endtask

    // Issue one request and follow it to done. Cycle 1 is the cycle after
    // the accepting edge. With poke set, extra starts (value 42) are pulsed
    // during CONV and LOAD1 and must be ignored.
    task automatic run(input bit hx, input logic [15:0] v, input int lat,
                       input bit poke, input string tag);
        int cyc;
        int l0;
        int s0;
        push_exp(hx, v);
        s0 = strobes;
        @(negedge clk);
        start = 1'b1; hex_mode = hx; value = v;
        @(negedge clk);
        start = 1'b0; hex_mode = ~hx; value = 16'h5A5A;
        cyc = 1;
        l0  = -1;
        chk({tag, "_busy"}, busy, 32'd1);
        while (done !== 1'b1 && cyc < 100) begin
            if (load0 === 1'b1) l0 = cyc;
            if (poke && (cyc == 5 || load1 === 1'b1)) begin
                start = 1'b1; hex_mode = 1'b0; value = 16'd42;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_lat"}, cyc, lat);
        chk({tag, "_load0_lat"}, l0, lat - 2);
        if (poke) begin
            @(negedge clk);
            chk({tag, "_idle_after"}, busy, 32'd0);
            @(negedge clk);
            chk({tag, "_still_idle"}, busy, 32'd0);
            chk({tag, "_strobes"}, strobes - s0, 32'd2);
        end
    endtask

    initial begin
        int c;
        int l0a;
        int l0b;
        rst = 1'b1; start = 1'b0; hex_mode = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_loads", {load1, load0}, 0);
        chk("rst_data", data, 0);
        rst = 1'b0;

        run(1'b0, 16'd1234,  19, 1'b0, "dec1234");
        chk("ovf1234", ovf, 0);
        run(1'b0, 16'hFFFF,  19, 1'b0, "decFFFF");
        chk("ovfFFFF", ovf, 1);
        run(1'b0, 16'd10000, 19, 1'b0, "dec10000");
        run(1'b0, 16'd9999,  19, 1'b0, "dec9999");
        chk("ovf9999", ovf, 0);
        run(1'b0, 16'd60000, 19, 1'b0, "dec60000");
        run(1'b1, 16'hBEEF,  3,  1'b0, "hexBEEF");
        chk("hex_clears_ovf", ovf, 0);
        run(1'b0, 16'd0,     19, 1'b0, "dec0");
        run(1'b0, 16'd1234,  19, 1'b1, "ignored");

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1; hex_mode = 1'b0; value = 16'd60000;
        @(negedge clk);
        start = 1'b0;
        chk("mid_ovf_set", ovf, 1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_loads", {load1, load0}, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run(1'b0, 16'd507, 19, 1'b0, "dec507");

        // start held high: back-to-back operations.
        push_exp(1'b0, 16'd1);
        push_exp(1'b0, 16'd1);
        @(negedge clk);
        start = 1'b1; hex_mode = 1'b0; value = 16'd1;
        c = 0; l0a = -1; l0b = -1;
        while (l0b < 0 && c < 200) begin
            @(negedge clk);
            c++;
            if (load0 === 1'b1) begin
                if (l0a < 0) l0a = c; else l0b = c;
            end
        end
        start = 1'b0;
        chk("held_gap", l0b - l0a, 20);
        c = 0;
        while (done !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("held_done", done, 1);
        repeat (3) @(negedge clk);
        chk("held_idle", busy, 0);
        chk("queue_empty", exp_q.size() + ovf_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
